// File: rtl/data_memory_pkg.sv
// Shared types and defaults for the data memory with a coalescing store buffer.
// Store-buffer entries carry the full 30-bit word index; range checking happens before enqueue.
package data_memory_pkg;

   localparam int DEPTH_DEF    = 64;
   localparam int SB_DEPTH_DEF = 4;
   localparam int IDX_W        = 30;

   typedef struct packed {
      logic             valid;
      logic [IDX_W-1:0] index;
      logic [31:0]      data;
   } sb_entry_t;

endpackage

// File: rtl/data_memory_if.sv
// CPU-side bus of the data memory. mem_write is a single-cycle strobe with no backpressure:
// every in-range store is accepted on the edge it is sampled, and loads return combinationally.
interface data_memory_if
   import data_memory_pkg::*;
#(
   parameter int SB_DEPTH = SB_DEPTH_DEF
);
   localparam int CW = $clog2(SB_DEPTH) + 1;

   logic          mem_write;
   logic [31:0]   data_memory_addr;
   logic [31:0]   write_data;
   logic          flush;
   logic [31:0]   read_data;
   logic [CW-1:0] sb_count;
   logic          sb_empty;
   logic          addr_error;

   modport master (
      output mem_write, data_memory_addr, write_data, flush,
      input  read_data, sb_count, sb_empty, addr_error
   );

   modport slave (
      input  mem_write, data_memory_addr, write_data, flush,
      output read_data, sb_count, sb_empty, addr_error
   );

endinterface

// File: rtl/data_memory_store_buffer.sv
// Store buffer: FIFO of pending stores with coalescing, youngest-match forwarding and
// a single drain port toward the array (at most one array write per cycle).
module store_buffer
   import data_memory_pkg::*;
#(
   parameter  int SB_DEPTH = SB_DEPTH_DEF,
   localparam int PW       = $clog2(SB_DEPTH),
   localparam int CW       = PW + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mem_write,
   input  logic             store_ok,
   input  logic [IDX_W-1:0] wr_index,
   input  logic [31:0]      wr_data,
   input  logic             flush,
   input  logic [IDX_W-1:0] rd_index,
   output logic             fwd_hit,
   output logic [31:0]      fwd_data,
   output logic             drain_en,
   output logic [IDX_W-1:0] drain_index,
   output logic [31:0]      drain_data,
   output logic [CW-1:0]    count
);

   sb_entry_t     sb_q [SB_DEPTH];
   sb_entry_t     sb_d [SB_DEPTH];
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;

   logic          match_hit;
   logic [PW-1:0] match_pos;
   logic          full, empty, coalesce, enqueue, head_coalesced;

   // Scan oldest to youngest so the last hit is the youngest entry.
   always_comb begin
      logic [PW-1:0] pos;
      match_hit = 1'b0;
      match_pos = '0;
      fwd_hit   = 1'b0;
      fwd_data  = '0;
      pos       = '0;
      for (int k = 0; k < SB_DEPTH; k++) begin
         pos = head_q + PW'(k);
         if (sb_q[pos].valid && (sb_q[pos].index == wr_index)) begin
            match_hit = 1'b1;
            match_pos = pos;
         end
         if (sb_q[pos].valid && (sb_q[pos].index == rd_index)) begin
            fwd_hit  = 1'b1;
            fwd_data = sb_q[pos].data;
         end
      end
   end

   assign full           = (count_q == CW'(SB_DEPTH));
   assign empty          = (count_q == '0);
   assign coalesce       = store_ok & match_hit;
   assign enqueue        = store_ok & ~match_hit;
   assign head_coalesced = coalesce & (match_pos == head_q);

   always_comb begin
      sb_d        = sb_q;
      head_d      = head_q;
      tail_d      = tail_q;
      drain_en    = ~empty & ((enqueue & full) | ~mem_write | flush);
      drain_index = sb_q[head_q].index;
      // A store coalescing into a draining head goes straight to the array.
      drain_data  = head_coalesced ? wr_data : sb_q[head_q].data;
      if (drain_en) begin
         sb_d[head_q].valid = 1'b0;
         head_d             = head_q + 1'b1;
      end
      if (coalesce && !(drain_en && head_coalesced)) begin
         sb_d[match_pos].data = wr_data;
      end
      if (enqueue) begin
         sb_d[tail_q] = '{valid: 1'b1, index: wr_index, data: wr_data};
         tail_d       = tail_q + 1'b1;
      end
      count_d = count_q + CW'(enqueue) - CW'(drain_en);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < SB_DEPTH; i++) begin
            sb_q[i] <= '0;
         end
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         sb_q    <= sb_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/data_memory.sv
// Word-addressed data memory fronted by a store buffer; loads are combinational and see
// buffered stores first. Out-of-range accesses read 0 and raise a sticky addr_error.
module data_memory
   import data_memory_pkg::*;
#(
   parameter int DEPTH    = DEPTH_DEF,
   parameter int SB_DEPTH = SB_DEPTH_DEF
) (
   input  logic          clk,
   input  logic          reset,
   data_memory_if.slave  bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(SB_DEPTH) + 1;

   logic [IDX_W-1:0] word_idx;
   logic             in_range;
   logic             store_ok;
   logic             fwd_hit;
   logic [31:0]      fwd_data;
   logic             sb_drain_en;
   logic [IDX_W-1:0] sb_drain_index;
   logic [31:0]      sb_drain_data;
   logic [CW-1:0]    sb_count;
   logic [31:0]      read_data;
   logic             addr_error_q, addr_error_d;
   logic             unused_bits;

   // Array contents are deliberately not reset.
   logic [31:0]      mem_q [DEPTH];

   assign word_idx    = bus.data_memory_addr[31:2];
   assign in_range    = (word_idx < IDX_W'(DEPTH));
   assign store_ok    = bus.mem_write & in_range;
   assign unused_bits = ^{bus.data_memory_addr[1:0], sb_drain_index[IDX_W-1:AW]};

   store_buffer #(.SB_DEPTH(SB_DEPTH)) u_sb (
      .clk         (clk),
      .reset       (reset),
      .mem_write   (bus.mem_write),
      .store_ok    (store_ok),
      .wr_index    (word_idx),
      .wr_data     (bus.write_data),
      .flush       (bus.flush),
      .rd_index    (word_idx),
      .fwd_hit     (fwd_hit),
      .fwd_data    (fwd_data),
      .drain_en    (sb_drain_en),
      .drain_index (sb_drain_index),
      .drain_data  (sb_drain_data),
      .count       (sb_count)
   );

   always_ff @(posedge clk) begin
      if (reset && sb_drain_en) begin
         mem_q[sb_drain_index[AW-1:0]] <= sb_drain_data;
      end
   end

   always_comb begin
      read_data = '0;
      if (in_range) begin
         read_data = fwd_hit ? fwd_data : mem_q[word_idx[AW-1:0]];
      end
   end

   assign addr_error_d = addr_error_q | ~in_range;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_error_q <= 1'b0;
      end else begin
         addr_error_q <= addr_error_d;
      end
   end

   assign bus.read_data  = read_data;
   assign bus.sb_count   = sb_count;
   assign bus.sb_empty   = (sb_count == '0);
   assign bus.addr_error = addr_error_q;

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the store buffer and array.
module tb_data_memory;
   import data_memory_pkg::*;

   localparam int DEPTH    = 64;
   localparam int SB_DEPTH = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   data_memory_if #(.SB_DEPTH(SB_DEPTH)) bus ();

   data_memory #(.DEPTH(DEPTH), .SB_DEPTH(SB_DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- reference model ----------------
   typedef struct {
      logic [29:0] idx;
      logic [31:0] data;
   } ent_t;

   ent_t        m_q[$];
   logic [31:0] m_mem [DEPTH];
   logic        m_err;
   logic [31:0] exp_q[$];
   int          n_checks = 0;
   int          n_pass   = 0;

   function automatic void retire();
      ent_t e;
      e = m_q.pop_front();
      m_mem[int'(e.idx)] = e.data;
   endfunction

   function automatic void model_edge();
      logic [29:0] idx;
      int          pre;
      int          hit;
      bit          in_rng;
      bit          forced;
      idx    = bus.data_memory_addr[31:2];
      in_rng = (idx < DEPTH);
      pre    = m_q.size();
      hit    = -1;
      forced = 0;
      if (!in_rng) m_err = 1'b1;
      if (bus.mem_write && in_rng) begin
         foreach (m_q[i]) if (m_q[i].idx == idx) hit = i;
         if (hit >= 0) begin
            m_q[hit].data = bus.write_data;
         end else begin
            if (pre == SB_DEPTH) begin
               retire();
               forced = 1;
            end
            m_q.push_back('{idx, bus.write_data});
         end
      end
      if (pre > 0 && !forced && (!bus.mem_write || bus.flush)) retire();
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] addr);
      logic [29:0] idx;
      logic [31:0] r;
      idx = addr[31:2];
      if (idx >= DEPTH) return 32'h0;
      r = m_mem[int'(idx)];
      foreach (m_q[i]) if (m_q[i].idx == idx) r = m_q[i].data;
      return r;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic apply(input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic fl);
      bus.mem_write        = we;
      bus.data_memory_addr = addr;
      bus.write_data       = wd;
      bus.flush            = fl;
      @(negedge clk);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic drain_all();
      repeat (SB_DEPTH + 1) begin
         apply(1'b0, 32'h0, 32'h0, 1'b0);
         tick();
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (bus.sb_count !== '0) $display("FAIL reset_count: got %0d want 0", bus.sb_count);
      else n_pass++;
      n_checks++;
      if (bus.sb_empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", bus.sb_empty);
      else n_pass++;
      n_checks++;
      if (bus.addr_error !== 1'b0) $display("FAIL reset_err: got %b want 0", bus.addr_error);
      else n_pass++;
      reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic preload();
      for (int i = 0; i < DEPTH; i++) begin
         apply(1'b1, 32'(i * 4), $urandom, 1'b0);
         tick();
      end
      drain_all();
   endtask

   task automatic test_forward();
      drain_all();
      apply(1'b1, 32'd8, 32'hdeadbeef, 1'b0);
      tick();
      apply(1'b0, 32'd8, 32'h0, 1'b0);
      n_checks++;
      if (bus.read_data !== 32'hdeadbeef) $display("FAIL fwd_read: got %h want deadbeef", bus.read_data);
      else n_pass++;
      n_checks++;
      if (bus.sb_count !== 3'd1) $display("FAIL fwd_count: got %0d want 1", bus.sb_count);
      else n_pass++;
      tick();
      apply(1'b0, 32'd8, 32'h0, 1'b0);
      n_checks++;
      if (bus.sb_count !== 3'd0) $display("FAIL fwd_drained_count: got %0d want 0", bus.sb_count);
      else n_pass++;
      n_checks++;
      if (bus.read_data !== 32'hdeadbeef) $display("FAIL fwd_array: got %h want deadbeef", bus.read_data);
      else n_pass++;
      tick();
   endtask

   task automatic test_back_to_back();
      drain_all();
      for (int i = 0; i < 5; i++) begin
         apply(1'b1, 32'(i * 4), 32'(i + 1), 1'b0);
         if (i > 0) begin
            n_checks++;
            if (int'(bus.sb_count) !== i) $display("FAIL b2b_count%0d: got %0d want %0d", i, bus.sb_count, i);
            else n_pass++;
         end
         tick();
      end
      apply(1'b0, 32'd0, 32'h0, 1'b0);
      n_checks++;
      if (bus.sb_count !== 3'd4) $display("FAIL b2b_full_count: got %0d want 4", bus.sb_count);
      else n_pass++;
      n_checks++;
      if (bus.read_data !== 32'd1) $display("FAIL b2b_forced_word0: got %h want 1", bus.read_data);
      else n_pass++;
      tick();
      for (int i = 1; i < 5; i++) begin
         apply(1'b0, 32'(i * 4), 32'h0, 1'b0);
         n_checks++;
         if (bus.read_data !== 32'(i + 1)) $display("FAIL b2b_read%0d: got %h want %h", i, bus.read_data, i + 1);
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_coalesce();
      drain_all();
      apply(1'b1, 32'd4, 32'd7, 1'b0);
      tick();
      apply(1'b1, 32'd4, 32'd9, 1'b0);
      n_checks++;
      if (bus.sb_count !== 3'd1) $display("FAIL coal_count_a: got %0d want 1", bus.sb_count);
      else n_pass++;
      tick();
      apply(1'b0, 32'd4, 32'h0, 1'b0);
      n_checks++;
      if (bus.sb_count !== 3'd1) $display("FAIL coal_count_b: got %0d want 1", bus.sb_count);
      else n_pass++;
      n_checks++;
      if (bus.read_data !== 32'd9) $display("FAIL coal_fwd: got %h want 9", bus.read_data);
      else n_pass++;
      tick();
      apply(1'b0, 32'd4, 32'h0, 1'b0);
      n_checks++;
      if (bus.read_data !== 32'd9 || bus.sb_count !== 3'd0)
         $display("FAIL coal_array: got %h/%0d want 9/0", bus.read_data, bus.sb_count);
      else n_pass++;
      tick();
   endtask

   task automatic test_flush();
      logic [31:0] vals [4];
      drain_all();
      for (int i = 0; i < 4; i++) begin
         vals[i] = $urandom;
         exp_q.push_back(vals[i]);
         apply(1'b1, 32'h40 + 32'(i * 4), vals[i], 1'b0);
         tick();
      end
      for (int c = 0; c < 4; c++) begin
         apply(1'b0, 32'h40 + 32'(c * 4), 32'h0, 1'b1);
         n_checks++;
         if (int'(bus.sb_count) !== 4 - c) $display("FAIL flush_count%0d: got %0d want %0d", c, bus.sb_count, 4 - c);
         else n_pass++;
         n_checks++;
         if (dut.sb_drain_en !== 1'b1 || dut.sb_drain_data !== exp_q[0])
            $display("FAIL flush_order%0d: got %b/%h want 1/%h", c, dut.sb_drain_en, dut.sb_drain_data, exp_q[0]);
         else n_pass++;
         void'(exp_q.pop_front());
         tick();
      end
      apply(1'b0, 32'h40, 32'h0, 1'b0);
      n_checks++;
      if (bus.sb_count !== 3'd0 || bus.sb_empty !== 1'b1)
         $display("FAIL flush_empty: got %0d/%b want 0/1", bus.sb_count, bus.sb_empty);
      else n_pass++;
      tick();
      for (int i = 0; i < 4; i++) begin
         apply(1'b0, 32'h40 + 32'(i * 4), 32'h0, 1'b0);
         n_checks++;
         if (bus.read_data !== vals[i]) $display("FAIL flush_array%0d: got %h want %h", i, bus.read_data, vals[i]);
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_random();
      logic        we, fl;
      logic [31:0] addr;
      drain_all();
      for (int n = 0; n < 300; n++) begin
         we   = ($urandom_range(0, 9) < 6);
         fl   = ($urandom_range(0, 3) == 0);
         addr = (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
         apply(we, addr, $urandom, fl);
         n_checks++;
         if (bus.read_data !== model_read(addr))
            $display("FAIL rnd_read@%0d: got %h want %h", n, bus.read_data, model_read(addr));
         else n_pass++;
         n_checks++;
         if (int'(bus.sb_count) !== m_q.size())
            $display("FAIL rnd_count@%0d: got %0d want %0d", n, bus.sb_count, m_q.size());
         else n_pass++;
         n_checks++;
         if (bus.sb_empty !== (m_q.size() == 0))
            $display("FAIL rnd_empty@%0d: got %b want %b", n, bus.sb_empty, m_q.size() == 0);
         else n_pass++;
         n_checks++;
         if (bus.addr_error !== m_err) $display("FAIL rnd_err@%0d: got %b want %b", n, bus.addr_error, m_err);
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_async_reset();
      logic [31:0] v;
      drain_all();
      for (int i = 0; i < 3; i++) begin
         apply(1'b1, 32'h80 + 32'(i * 4), ~m_mem[32 + i], 1'b0);
         tick();
      end
      #2;
      reset = 1'b0;
      #1;
      n_checks++;
      if (bus.sb_count !== 3'd0 || bus.sb_empty !== 1'b1)
         $display("FAIL async_reset: got %0d/%b want 0/1", bus.sb_count, bus.sb_empty);
      else n_pass++;
      m_q.delete();
      m_err = 1'b0;
      bus.mem_write = 1'b0;
      bus.flush     = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      v = $urandom;
      bus.mem_write        = 1'b1;
      bus.data_memory_addr = 32'h90;
      bus.write_data       = v;
      tick();
      apply(1'b0, 32'h90, 32'h0, 1'b0);
      n_checks++;
      if (bus.sb_count !== 3'd1 || bus.read_data !== v)
         $display("FAIL post_reset_store: got %0d/%h want 1/%h", bus.sb_count, bus.read_data, v);
      else n_pass++;
      tick();
      for (int i = 0; i < 3; i++) begin
         apply(1'b0, 32'h80 + 32'(i * 4), 32'h0, 1'b0);
         n_checks++;
         if (bus.read_data !== m_mem[32 + i])
            $display("FAIL reset_retain%0d: got %h want %h", i, bus.read_data, m_mem[32 + i]);
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_addr_error();
      drain_all();
      apply(1'b1, 32'h10, 32'h1111, 1'b0);
      n_checks++;
      if (bus.addr_error !== 1'b0) $display("FAIL err_clear: got %b want 0", bus.addr_error);
      else n_pass++;
      tick();
      apply(1'b1, 32'h400, 32'h1234, 1'b0);
      n_checks++;
      if (bus.read_data !== 32'h0 || bus.sb_count !== 3'd1)
         $display("FAIL oor_store_pre: got %h/%0d want 0/1", bus.read_data, bus.sb_count);
      else n_pass++;
      tick();
      apply(1'b1, 32'h14, 32'h2222, 1'b0);
      n_checks++;
      if (bus.addr_error !== 1'b1 || bus.sb_count !== 3'd1)
         $display("FAIL oor_store_post: got %b/%0d want 1/1", bus.addr_error, bus.sb_count);
      else n_pass++;
      tick();
      apply(1'b0, 32'h400, 32'h0, 1'b0);
      n_checks++;
      if (bus.read_data !== 32'h0) $display("FAIL oor_read: got %h want 0", bus.read_data);
      else n_pass++;
      tick();
      for (int i = 0; i < 5; i++) begin
         apply(1'b0, 32'h10, 32'h0, 1'b0);
         n_checks++;
         if (bus.addr_error !== 1'b1) $display("FAIL err_sticky%0d: got %b want 1", i, bus.addr_error);
         else n_pass++;
         tick();
      end
      #2;
      reset = 1'b0;
      #1;
      n_checks++;
      if (bus.addr_error !== 1'b0) $display("FAIL err_reset: got %b want 0", bus.addr_error);
      else n_pass++;
      m_q.delete();
      m_err = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      reset                = 1'b0;
      bus.mem_write        = 1'b0;
      bus.data_memory_addr = 32'h0;
      bus.write_data       = 32'h0;
      bus.flush            = 1'b0;
      m_err                = 1'b0;
      test_reset();
      preload();
      test_forward();
      test_back_to_back();
      test_coalesce();
      test_flush();
      test_random();
      test_async_reset();
      test_addr_error();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter DEPTH, default 64: number of 32-bit words in the storage array; a power of two, at least 4.
REQ-002 Parameter SB_DEPTH, default 4: number of store-buffer entries; a power of two, at least 2.
REQ-003 Port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 Port mem_write  input  1  CPU store strobe, sampled on the rising edge of clk.
REQ-006 Port data_memory_addr  input  32  CPU byte address.
REQ-007 Port write_data  input  32  CPU store data.
REQ-008 Port flush  input  1  request to drain the store buffer, one entry per cycle.
REQ-009 Port read_data  output  32  combinational load data for data_memory_addr.
REQ-010 Port sb_count  output  $clog2(SB_DEPTH)+1  number of occupied store-buffer entries.
REQ-011 Port sb_empty  output  1  high when sb_count == 0.
REQ-012 Port addr_error  output  1  sticky out-of-range access flag.

Function
REQ-013 Word index = data_memory_addr[31:2]; bits [1:0] are ignored; an access is in range when the word index is < DEPTH.
REQ-014 read_data is combinational, with zero-cycle latency, so that a single-cycle CPU loads in the same cycle.
REQ-015 read_data priority: youngest valid store-buffer entry with a matching index, otherwise the array word, otherwise 0 when the access is out of range.
REQ-016 In-range mem_write with a matching buffer entry: overwrite that entry's data (coalesce); sb_count is unchanged.
REQ-017 In-range mem_write with no matching entry and the buffer not full: enqueue {index, data} at the tail; sb_count +1.
REQ-018 In-range mem_write with no matching entry and the buffer full: forced drain. The head is written to the array and the new store is enqueued in the same edge; sb_count is unchanged.
REQ-019 Normal drain: on an edge with mem_write=0 and the buffer non-empty, the head is written to the array; sb_count -1.
REQ-020 flush=1 with mem_write=1: the store is handled per REQ-016..018, and one head entry additionally drains unless the store already forced a drain. Net sb_count never exceeds SB_DEPTH.
REQ-021 At most one array write occurs per cycle.
REQ-022 Buffer entries drain in FIFO order.
REQ-023 Head/tail pointers wrap modulo SB_DEPTH.
REQ-024 A coalesced entry keeps its original queue position.
REQ-025 Out-of-range mem_write: the store is dropped with no buffer or array change; addr_error is set on that edge.
REQ-026 Out-of-range read (mem_write=0): read_data=0; addr_error is set on the next edge.
REQ-027 addr_error clears only on reset.
REQ-028 A forwarded read of an entry being drained on the same edge returns the buffered data before the edge and the array data after the edge; both values are identical.

Reset
REQ-029 While reset=0: sb_count=0, sb_empty=1, addr_error=0, and all entry valid bits are cleared; pending stores are discarded.
REQ-030 Array contents are not reset; they are undefined at power-up and retained across reset.
REQ-031 Reset asserted mid-drain aborts the drain; no partial array write occurs.
REQ-032 After reset deasserts, the first rising edge accepts a store normally.

Structure
REQ-033 A shared package holds the store-buffer entry struct {valid, index, data} and the default DEPTH/SB_DEPTH constants.
REQ-034 One sub-module, store_buffer, holds the FIFO, coalescing match, youngest-match forwarding, and pointers. data_memory holds the array, range check, read mux, and addr_error.

Verification
REQ-035 Store 32'hdeadbeef to addr 8, then read addr 8 in the following cycle with mem_write=0 -> read_data=32'hdeadbeef (forwarded); after the next edge sb_count=0 and the array word 2 = 32'hdeadbeef.
REQ-036 Back-to-back stores to addrs 0,4,8,12,16 (values 1..5) -> sb_count 1,2,3,4,4; the fifth store forces array word 0 = 1; reads of all five addrs return 1..5.
REQ-037 Store 7 to addr 4, then 9 to addr 4 on the next edge -> sb_count stays 1; read addr 4 = 9; after the drain the array word 1 = 9.
REQ-038 Store to addr 32'h00000400 (index 256 ≥ 64) -> addr_error=1, sb_count unchanged; read of addr 32'h400 returns 0; addr_error stays 1 until reset.
REQ-039 Three buffered stores, then assert reset=0 asynchronously between edges -> sb_count=0 immediately; the array words for those stores keep their prior values.
REQ-040 Fill the buffer (4 entries) and hold flush=1 with mem_write=0 for 4 cycles -> sb_count 3,2,1,0, the array updated in FIFO order, sb_empty=1.
